alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the core's single combinational `alu` between `NUM_REQ` requesters, such as hardware thread contexts or a debug/inject port. Each cycle the arbiter selects one valid requester by round-robin and drives that requester's operands and instruction into the ALU. It registers the ALU result and branch decision into a one-entry response slot, which has a valid/ready handshake toward the consumer. The block sits between the decode/register-read stage of the requesters and the shared `alu` instance.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..8.
- `ID_W`, derived localparam `$clog2(NUM_REQ)`: width of the requester index.
- `clk`  in  1: core clock, rising-edge.
- `n_reset`  in  1: reset, asynchronous and active-low.
- `req_valid_i`  in  `NUM_REQ`: requester i has an operation pending.
- `req_ready_o`  out  `NUM_REQ`: one-hot grant; bit i high means requester i's operation is accepted this cycle.
- `req_rd_i`  in  `NUM_REQ`×32: rd operand per requester.
- `req_rs_i`  in  `NUM_REQ`×32: rs operand per requester.
- `req_op_i`  in  `NUM_REQ`×`instruction_s`: instruction per requester.
- `alu_rd_o`  out  32: rd to the shared ALU.
- `alu_rs_o`  out  32: rs to the shared ALU.
- `alu_op_o`  out  `instruction_s`: instruction to the shared ALU.
- `alu_result_i`  in  32: ALU `result_o`.
- `alu_jump_now_i`  in  1: ALU `jump_now_o`.
- `resp_valid_o`  out  1: the response slot is occupied.
- `resp_id_o`  out  `ID_W`: index of the requester that owns the response.
- `resp_result_o`  out  32: registered ALU result.
- `resp_jump_now_o`  out  1: registered branch decision.
- `resp_ready_i`  in  1: the consumer takes the response this cycle.
- `ops_count_o`  out  16: count of accepted operations; wraps at 0xFFFF→0.

## Operation
- Slot free: `slot_free = !resp_valid_o || resp_ready_i`. A response that drains in the same cycle frees the slot.
- Grant: when `slot_free` and any `req_valid_i` is set, the winner is the first set bit searching upward from `last_grant+1` modulo `NUM_REQ`.
  - `req_ready_o` is one-hot on the winner.
  - Otherwise `req_ready_o` is 0.
- ALU drive:
  - With a winner, `alu_rd_o`, `alu_rs_o` and `alu_op_o` equal the winner's inputs.
  - With no winner, all three are driven to zero, which is the all-zero NOP encoding.
- Accept, on the clock edge with a winner:
  - `resp_result_o` ← `alu_result_i`.
  - `resp_jump_now_o` ← `alu_jump_now_i`.
  - `resp_id_o` ← winner.
  - `resp_valid_o` ← 1.
  - `last_grant` ← winner.
  - `ops_count_o` increments.
- Drain without accept: if `resp_valid_o && resp_ready_i` and there is no winner, `resp_valid_o` ← 0. Payload registers keep their last value.
- Backpressure: while `resp_valid_o && !resp_ready_i`, all `resp_*` outputs hold stable, `req_ready_o` is 0 and `last_grant` is frozen.
- Requester contract: hold `req_valid_i` and operands stable until granted. `req_valid_i` must not depend on `req_ready_o`.
- The arbiter does not inspect opcodes. Branch ops (`kBEQZ`, etc.) and jump-less ops are treated identically.

## Timing
- Reset (`n_reset` low, asynchronous):
  - `resp_valid_o`=0, `resp_id_o`=0, `resp_result_o`=0, `resp_jump_now_o`=0, `ops_count_o`=0.
  - `last_grant`=`NUM_REQ-1`, so requester 0 has first priority.
  - `req_ready_o` and `alu_*` follow combinationally; with `resp_valid_o`=0 a request can be granted in the first cycle after reset release.
- Reset asserted mid-operation: a pending response is discarded and no partial state survives.
- Latency: grant in cycle N, so `resp_valid_o` is high in N+1.
- Throughput: one operation per cycle when `resp_ready_i` is held high.
- Combinational paths:
  - `req_*` → `alu_*` → response D-inputs: a single ALU traversal per cycle.
  - `resp_ready_i` → `req_ready_o`.
  - No combinational path from `req_*` to `resp_*`.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,`NUM_REQ-1`,0. No requester waits more than `NUM_REQ-1` grants.
- Simultaneous drain and accept in one cycle: the slot is reloaded and `resp_valid_o` stays 1.

## Test plan
- Single request: requester 0 sends `kADDU` with rd=5, rs=7 while `resp_ready_i`=1.
  - Required: `req_ready_o`=01 the same cycle.
  - Next cycle: `resp_valid_o`=1, `resp_id_o`=0, `resp_result_o`=12, `ops_count_o`=1.
- Round-robin: both requesters hold `kSUBU` with rd=10, rs=3 for 6 cycles with `resp_ready_i`=1.
  - Required grant sequence: 0,1,0,1,0,1.
  - Every response is 7; `ops_count_o`=6.
- Backpressure: `resp_ready_i`=0 for 4 cycles after a `kSLT` with rd=0xFFFFFFFF, rs=1.
  - Required: `resp_result_o`=1 holds stable, `req_ready_o`=0 throughout.
  - On release: drain and a new grant happen in the same cycle.
- Branch: requester 1 sends `kBLTZ` with rd=0x80000000.
  - Required: `resp_jump_now_o`=1, `resp_id_o`=1, `resp_result_o`=0.
- Reset mid-stream: assert `n_reset` while `resp_valid_o`=1.
  - Required: outputs zero immediately.
  - After release, the first grant goes to requester 0 even if both requesters are valid.
- Counter wrap: preload via 65536 accepted ops.
  - Required: `ops_count_o` rolls from 0xFFFF to 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters
// and parks each result in a one-entry valid/ready response slot.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int OP_W    = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*32-1:0]   req_rd_i,
  input  logic [NUM_REQ*32-1:0]   req_rs_i,
  input  logic [NUM_REQ*OP_W-1:0] req_op_i,
  output logic [31:0]             alu_rd_o,
  output logic [31:0]             alu_rs_o,
  output logic [OP_W-1:0]         alu_op_o,
  input  logic [31:0]             alu_result_i,
  input  logic                    alu_jump_now_i,
  output logic                    resp_valid_o,
  output logic [ID_W-1:0]         resp_id_o,
  output logic [31:0]             resp_result_o,
  output logic                    resp_jump_now_o,
  input  logic                    resp_ready_i,
  output logic [15:0]             ops_count_o
);

  logic            r_resp_valid;
  logic [ID_W-1:0] r_resp_id;
  logic [31:0]     r_resp_result;
  logic            r_resp_jump;
  logic [15:0]     r_ops_count;
  logic [ID_W-1:0] r_last_grant;

  logic            w_slot_free;
  logic            w_found;
  logic            w_grant;
  logic [ID_W-1:0] w_winner;

  assign w_slot_free = !r_resp_valid || resp_ready_i;
  assign w_grant     = w_slot_free && w_found;

  // Round-robin: indices above the last grant win first, then wrap to the low indices.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid_i[i] && (ID_W'(i) > r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid_i[i] && (ID_W'(i) <= r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = ID_W'(i);
      end
    end
  end

  // Idle cycles present the all-zero NOP to the ALU.
  always_comb begin
    req_ready_o = '0;
    alu_rd_o    = '0;
    alu_rs_o    = '0;
    alu_op_o    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant && (w_winner == ID_W'(i))) begin
        req_ready_o[i] = 1'b1;
        alu_rd_o       = req_rd_i[i*32 +: 32];
        alu_rs_o       = req_rs_i[i*32 +: 32];
        alu_op_o       = req_op_i[i*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_resp_valid  <= 1'b0;
      r_resp_id     <= '0;
      r_resp_result <= '0;
      r_resp_jump   <= 1'b0;
      r_ops_count   <= '0;
      r_last_grant  <= ID_W'(NUM_REQ - 1);
    end else if (w_grant) begin
      r_resp_valid  <= 1'b1;
      r_resp_id     <= w_winner;
      r_resp_result <= alu_result_i;
      r_resp_jump   <= alu_jump_now_i;
      r_ops_count   <= r_ops_count + 16'd1;
      r_last_grant  <= w_winner;
    end else if (resp_ready_i) begin
      r_resp_valid  <= 1'b0;
    end
  end

  assign resp_valid_o    = r_resp_valid;
  assign resp_id_o       = r_resp_id;
  assign resp_result_o   = r_resp_result;
  assign resp_jump_now_o = r_resp_jump;
  assign ops_count_o     = r_ops_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU drives the shared ALU port
// and a transaction-level model predicts grants and the response slot.
module tb_alu_arbiter;
  localparam int N    = 2;
  localparam int OP_W = 8;
  localparam int ID_W = $clog2(N);

  localparam logic [7:0] kNOP  = 8'd0;
  localparam logic [7:0] kADDU = 8'd1;
  localparam logic [7:0] kSUBU = 8'd2;
  localparam logic [7:0] kSLT  = 8'd3;
  localparam logic [7:0] kBLTZ = 8'd4;
  localparam logic [7:0] kBEQZ = 8'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                n_reset;
  logic [N-1:0]        req_valid_i;
  logic [N-1:0]        req_ready_o;
  logic [N*32-1:0]     req_rd_i;
  logic [N*32-1:0]     req_rs_i;
  logic [N*OP_W-1:0]   req_op_i;
  logic [31:0]         alu_rd_o;
  logic [31:0]         alu_rs_o;
  logic [OP_W-1:0]     alu_op_o;
  logic [31:0]         alu_result_i;
  logic                alu_jump_now_i;
  logic                resp_valid_o;
  logic [ID_W-1:0]     resp_id_o;
  logic [31:0]         resp_result_o;
  logic                resp_jump_now_o;
  logic                resp_ready_i;
  logic [15:0]         ops_count_o;

  logic [31:0] rd_a [N];
  logic [31:0] rs_a [N];
  logic [7:0]  op_a [N];

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.NUM_REQ(N), .OP_W(OP_W)) dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rd_i(req_rd_i), .req_rs_i(req_rs_i), .req_op_i(req_op_i),
    .alu_rd_o(alu_rd_o), .alu_rs_o(alu_rs_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .alu_jump_now_i(alu_jump_now_i),
    .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o),
    .resp_result_o(resp_result_o), .resp_jump_now_o(resp_jump_now_o),
    .resp_ready_i(resp_ready_i), .ops_count_o(ops_count_o)
  );

  // Behavioural ALU: returns {jump, result}
  function automatic logic [32:0] alu_f(input logic [7:0] op, input logic [31:0] rd, input logic [31:0] rs);
    logic [31:0] r;
    logic        j;
    r = 32'd0;
    j = 1'b0;
    case (op)
      kADDU: r = rd + rs;
      kSUBU: r = rd - rs;
      kSLT:  r = ($signed(rd) < $signed(rs)) ? 32'd1 : 32'd0;
      kBLTZ: j = rd[31];
      kBEQZ: j = (rd == 32'd0);
      default: r = 32'd0;
    endcase
    return {j, r};
  endfunction

  always_comb begin
    req_rd_i = '0;
    req_rs_i = '0;
    req_op_i = '0;
    for (int i = 0; i < N; i++) begin
      req_rd_i[i*32 +: 32]     = rd_a[i];
      req_rs_i[i*32 +: 32]     = rs_a[i];
      req_op_i[i*OP_W +: OP_W] = op_a[i];
    end
  end

  always_comb {alu_jump_now_i, alu_result_i} = alu_f(alu_op_o, alu_rd_o, alu_rs_o);

  // Transaction-level reference model
  int          m_last;
  bit          m_valid;
  int          m_id;
  logic [31:0] m_result;
  bit          m_jump;
  int          m_count;
  bit          e_grant;
  int          e_win;
  logic [N-1:0] e_ready;
  logic [31:0] e_rd;
  logic [7:0]  e_op;

  task automatic model_reset();
    m_last = N - 1; m_valid = 0; m_id = 0; m_result = 0; m_jump = 0; m_count = 0;
  endtask

  task automatic model_predict();
    e_grant = 0; e_win = 0; e_ready = '0; e_rd = 0; e_op = kNOP;
    if (!m_valid || resp_ready_i) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!e_grant && req_valid_i[c]) begin
          e_grant = 1; e_win = c;
        end
      end
    end
    if (e_grant) begin
      e_ready[e_win] = 1'b1;
      e_rd = rd_a[e_win];
      e_op = op_a[e_win];
    end
  endtask

  task automatic model_commit();
    if (e_grant) begin
      {m_jump, m_result} = alu_f(op_a[e_win], rd_a[e_win], rs_a[e_win]);
      m_id = e_win; m_valid = 1; m_last = e_win;
      m_count = (m_count + 1) % 65536;
    end else if (m_valid && resp_ready_i) begin
      m_valid = 0;
    end
  endtask

  task automatic apply_reset();
    n_reset = 1'b0;
    req_valid_i = '0;
    resp_ready_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd_a[i] = 0; rs_a[i] = 0; op_a[i] = kNOP;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    tests++;
    if (resp_valid_o !== 1'b0 || resp_id_o !== '0 || resp_result_o !== 32'd0 ||
        resp_jump_now_o !== 1'b0 || ops_count_o !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: got v=%b id=%0d res=%0h j=%b cnt=%0d, expected all zero",
               resp_valid_o, resp_id_o, resp_result_o, resp_jump_now_o, ops_count_o);
    end
    tests++;
    if (req_ready_o !== '0 || alu_op_o !== '0) begin
      fails++;
      $display("[TB] FAIL reset_idle: got ready=%b op=%0h, expected 0", req_ready_o, alu_op_o);
    end
  endtask

  task automatic test_single();
    op_a[0] = kADDU; rd_a[0] = 32'd5; rs_a[0] = 32'd7;
    req_valid_i = 2'b01; resp_ready_i = 1'b1;
    #1 model_predict();
    tests++;
    if (req_ready_o !== 2'b01 || alu_rd_o !== 32'd5 || alu_rs_o !== 32'd7) begin
      fails++;
      $display("[TB] FAIL single_grant: got ready=%b rd=%0d rs=%0d, expected 01 5 7", req_ready_o, alu_rd_o, alu_rs_o);
    end
    @(posedge clk); model_commit(); #1;
    req_valid_i = '0;
    tests++;
    if (resp_valid_o !== 1'b1 || resp_id_o !== '0 || resp_result_o !== 32'd12 || ops_count_o !== 16'd1) begin
      fails++;
      $display("[TB] FAIL single_resp: got v=%b id=%0d res=%0d cnt=%0d, expected 1 0 12 1",
               resp_valid_o, resp_id_o, resp_result_o, ops_count_o);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < N; i++) begin
      op_a[i] = kSUBU; rd_a[i] = 32'd10; rs_a[i] = 32'd3;
    end
    req_valid_i = '1; resp_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 model_predict();
      tests++;
      if (req_ready_o !== (N'(1) << (c % N)) || req_ready_o !== e_ready) begin
        fails++;
        $display("[TB] FAIL rr_grant[%0d]: got %b, expected %b", c, req_ready_o, e_ready);
      end
      @(posedge clk); model_commit(); #1;
      tests++;
      if (resp_valid_o !== 1'b1 || resp_result_o !== 32'd7 || resp_id_o !== ID_W'(c % N)) begin
        fails++;
        $display("[TB] FAIL rr_resp[%0d]: got v=%b id=%0d res=%0d, expected 1 %0d 7",
                 c, resp_valid_o, resp_id_o, resp_result_o, c % N);
      end
    end
    tests++;
    if (ops_count_o !== 16'd6) begin
      fails++;
      $display("[TB] FAIL rr_count: got %0d, expected 6", ops_count_o);
    end
    req_valid_i = '0;
  endtask

  task automatic test_backpressure();
    op_a[0] = kSLT; rd_a[0] = 32'hFFFF_FFFF; rs_a[0] = 32'd1;
    req_valid_i = 2'b01; resp_ready_i = 1'b1;
    #1 model_predict();
    @(posedge clk); model_commit(); #1;
    req_valid_i = 2'b10; resp_ready_i = 1'b0;
    op_a[1] = kADDU; rd_a[1] = 32'd2; rs_a[1] = 32'd3;
    for (int c = 0; c < 4; c++) begin
      #1 model_predict();
      tests++;
      if (req_ready_o !== '0 || alu_op_o !== '0) begin
        fails++;
        $display("[TB] FAIL bp_ready[%0d]: got ready=%b op=%0h, expected 0", c, req_ready_o, alu_op_o);
      end
      @(posedge clk); model_commit(); #1;
      tests++;
      if (resp_valid_o !== 1'b1 || resp_result_o !== 32'd1 || resp_id_o !== '0) begin
        fails++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b id=%0d res=%0h, expected 1 0 1",
                 c, resp_valid_o, resp_id_o, resp_result_o);
      end
    end
    resp_ready_i = 1'b1;
    #1 model_predict();
    tests++;
    if (req_ready_o !== 2'b10) begin
      fails++;
      $display("[TB] FAIL bp_release_grant: got %b, expected 10", req_ready_o);
    end
    @(posedge clk); model_commit(); #1;
    tests++;
    if (resp_valid_o !== 1'b1 || resp_id_o !== ID_W'(1) || resp_result_o !== 32'd5) begin
      fails++;
      $display("[TB] FAIL bp_reload: got v=%b id=%0d res=%0d, expected 1 1 5", resp_valid_o, resp_id_o, resp_result_o);
    end
  endtask

  task automatic test_branch();
    op_a[1] = kBLTZ; rd_a[1] = 32'h8000_0000; rs_a[1] = 32'd0;
    req_valid_i = 2'b10; resp_ready_i = 1'b1;
    #1 model_predict();
    @(posedge clk); model_commit(); #1;
    req_valid_i = '0;
    tests++;
    if (resp_jump_now_o !== 1'b1 || resp_id_o !== ID_W'(1) || resp_result_o !== 32'd0) begin
      fails++;
      $display("[TB] FAIL branch: got j=%b id=%0d res=%0h, expected 1 1 0", resp_jump_now_o, resp_id_o, resp_result_o);
    end
  endtask

  task automatic test_reset_mid();
    resp_ready_i = 1'b0;
    n_reset = 1'b0;
    #1;
    tests++;
    if (resp_valid_o !== 1'b0 || resp_jump_now_o !== 1'b0 || resp_id_o !== '0 ||
        resp_result_o !== 32'd0 || ops_count_o !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid: got v=%b j=%b id=%0d res=%0h cnt=%0d, expected all zero",
               resp_valid_o, resp_jump_now_o, resp_id_o, resp_result_o, ops_count_o);
    end
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = kADDU; rd_a[i] = 32'(i); rs_a[i] = 32'd100;
    end
    req_valid_i = '1; resp_ready_i = 1'b1;
    #1 model_predict();
    tests++;
    if (req_ready_o !== 2'b01) begin
      fails++;
      $display("[TB] FAIL reset_first_grant: got %b, expected 01", req_ready_o);
    end
    @(posedge clk); model_commit(); #1;
    req_valid_i = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          op_a[i] = 8'($urandom_range(1, 5));
          rd_a[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
          rs_a[i] = $urandom;
        end
      end
      req_valid_i = pend;
      resp_ready_i = ($urandom_range(0, 3) != 0);
      #1 model_predict();
      tests++;
      if (req_ready_o !== e_ready || alu_rd_o !== e_rd || alu_op_o !== e_op) begin
        fails++;
        $display("[TB] FAIL rand_grant[%0d]: got ready=%b rd=%0h op=%0h, expected %b %0h %0h",
                 c, req_ready_o, alu_rd_o, alu_op_o, e_ready, e_rd, e_op);
      end
      @(posedge clk); model_commit(); #1;
      if (e_grant) pend[e_win] = 1'b0;
      tests++;
      if (resp_valid_o !== m_valid || resp_id_o !== ID_W'(m_id) || resp_result_o !== m_result ||
          resp_jump_now_o !== m_jump || ops_count_o !== 16'(m_count)) begin
        fails++;
        $display("[TB] FAIL rand_resp[%0d]: got v=%b id=%0d res=%0h j=%b cnt=%0d, expected %b %0d %0h %b %0d",
                 c, resp_valid_o, resp_id_o, resp_result_o, resp_jump_now_o, ops_count_o,
                 m_valid, m_id, m_result, m_jump, m_count);
      end
    end
    req_valid_i = '0;
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    op_a[0] = kADDU; rd_a[0] = 32'd1; rs_a[0] = 32'd1;
    req_valid_i = 2'b01; resp_ready_i = 1'b1;
    for (int c = 0; c < 65535; c++) begin
      #1 model_predict();
      @(posedge clk); model_commit(); #1;
    end
    tests++;
    if (ops_count_o !== 16'hFFFF) begin
      fails++;
      $display("[TB] FAIL wrap_max: got %0h, expected ffff", ops_count_o);
    end
    #1 model_predict();
    @(posedge clk); model_commit(); #1;
    tests++;
    if (ops_count_o !== 16'h0000 || resp_valid_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wrap_zero: got cnt=%0h v=%b, expected 0 1", ops_count_o, resp_valid_o);
    end
    req_valid_i = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_branch();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
